// File: rtl/synth_pkg.sv
// Shared widths, FSM state encoding and the host command payload for the voice sequencer.
package synth_pkg;

  localparam int unsigned PHASE_W      = 20;
  localparam int unsigned VOICE_ADDR_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOST = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_HOST = ST_HOST,
    S_ACK  = ST_ACK
  } state_t;

  // Host request captured in IDLE and replayed against the RAM in HOST.
  typedef struct packed {
    logic                    we;
    logic [VOICE_ADDR_W-1:0] addr;
    logic [PHASE_W-1:0]      wdata;
  } host_cmd_t;

endpackage

// File: rtl/ram64_voice_sequencer_if.sv
// Host word-access port of the voice sequencer.
//  master: host side (drives req/we/addr/wdata, receives ack/rdata)
//  slave : sequencer side
interface ram64_voice_sequencer_if;

  logic                              host_req;
  logic                              host_we;
  logic [synth_pkg::VOICE_ADDR_W-1:0] host_addr;
  logic [synth_pkg::PHASE_W-1:0]      host_wdata;
  logic                              host_ack;
  logic [synth_pkg::PHASE_W-1:0]      host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/ram64_voice_sequencer.sv
// Shares the 64x20 voice RAM between a per-sample phase-accumulator scan and a host port.
// Ports:
//  clk, rst_n           clock, async active-low reset
//  sample_tick          starts a sweep over voices 0..NUM_VOICES-1
//  inc_addr / inc_data  combinational increment lookup for the current scan voice
//  phase_valid/voice/out  registered pre-update phase stream, one voice per cycle
//  sweep_done           pulse alongside the last phase_valid
//  overrun/overrun_clr  sticky lost-tick flag and its clear (set wins)
//  host                 host word read/write port (slave modport)
//  ram_load/sel/in/out  RAM64 control; ram_out is a combinational read of ram_sel
module ram64_voice_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W     = PHASE_W,
  parameter int unsigned ADDR_W     = VOICE_ADDR_W,
  parameter int unsigned NUM_VOICES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] inc_addr,
  input  logic [DATA_W-1:0] inc_data,
  output logic              phase_valid,
  output logic [ADDR_W-1:0] phase_voice,
  output logic [DATA_W-1:0] phase_out,
  output logic              sweep_done,
  output logic              overrun,
  input  logic              overrun_clr,
  ram64_voice_sequencer_if.slave host,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_sel,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] LAST_V = ADDR_W'(NUM_VOICES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] v, v_nxt;
  logic              pending, pending_nxt;
  logic              overrun_set;
  host_cmd_t         cmd, cmd_nxt;

  // Scan index doubles as the increment lookup address.
  assign inc_addr = v;

  // FSM state and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      v       <= '0;
      pending <= 1'b0;
      cmd     <= '0;
    end else begin
      state   <= state_nxt;
      v       <= v_nxt;
      pending <= pending_nxt;
      cmd     <= cmd_nxt;
    end
  end

  // Next state, RAM control and tick bookkeeping.
  always_comb begin
    state_nxt   = state;
    v_nxt       = v;
    pending_nxt = pending;
    overrun_set = 1'b0;
    cmd_nxt     = cmd;
    ram_load    = 1'b0;
    ram_sel     = v;
    ram_in      = '0;
    unique case (state)
      S_IDLE: begin
        // A tick (fresh or deferred) always wins over a host request.
        if (sample_tick || pending) begin
          state_nxt   = S_SCAN;
          v_nxt       = '0;
          pending_nxt = 1'b0;
        end else if (host.host_req) begin
          cmd_nxt   = '{we: host.host_we, addr: host.host_addr, wdata: host.host_wdata};
          state_nxt = S_HOST;
        end
      end
      S_SCAN: begin
        ram_load = 1'b1;
        ram_in   = ram_out + inc_data;
        if (sample_tick) overrun_set = 1'b1;
        if (v == LAST_V) state_nxt = S_IDLE;
        else             v_nxt     = v + ADDR_W'(1);
      end
      S_HOST: begin
        ram_sel   = cmd.addr;
        ram_load  = cmd.we;
        ram_in    = cmd.wdata;
        state_nxt = S_ACK;
        if (sample_tick) begin
          if (pending) overrun_set = 1'b1;
          else         pending_nxt = 1'b1;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
        if (sample_tick) begin
          if (pending) overrun_set = 1'b1;
          else         pending_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: phase stream, sweep/host completion and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_valid     <= 1'b0;
      phase_voice     <= '0;
      phase_out       <= '0;
      sweep_done      <= 1'b0;
      overrun         <= 1'b0;
      host.host_ack   <= 1'b0;
      host.host_rdata <= '0;
    end else begin
      phase_valid   <= (state == S_SCAN);
      sweep_done    <= (state == S_SCAN) && (v == LAST_V);
      overrun       <= overrun_set | (overrun & ~overrun_clr);
      host.host_ack <= (state == S_HOST);
      if (state == S_SCAN) begin
        phase_voice <= v;
        phase_out   <= ram_out;
      end
      if ((state == S_HOST) && !cmd.we) host.host_rdata <= ram_out;
    end
  end

endmodule

// File: tb/tb_ram64_voice_sequencer.sv
// Self-checking bench: behavioural RAM64 + increment table behind the sequencer,
// reference phase memory updated by the accumulate rule.
module tb_ram64_voice_sequencer;
  import synth_pkg::*;

  localparam int unsigned DW = PHASE_W;
  localparam int unsigned AW = VOICE_ADDR_W;
  localparam int unsigned NV = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_tick;
  logic [AW-1:0] inc_addr;
  logic [DW-1:0] inc_data;
  logic          phase_valid;
  logic [AW-1:0] phase_voice;
  logic [DW-1:0] phase_out;
  logic          sweep_done;
  logic          overrun;
  logic          overrun_clr;
  logic          ram_load;
  logic [AW-1:0] ram_sel;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;

  ram64_voice_sequencer_if hif ();

  always #5 clk = ~clk;

  ram64_voice_sequencer #(.DATA_W(DW), .ADDR_W(AW), .NUM_VOICES(NV)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .inc_addr(inc_addr), .inc_data(inc_data),
    .phase_valid(phase_valid), .phase_voice(phase_voice), .phase_out(phase_out),
    .sweep_done(sweep_done), .overrun(overrun), .overrun_clr(overrun_clr),
    .host(hif),
    .ram_load(ram_load), .ram_sel(ram_sel), .ram_in(ram_in), .ram_out(ram_out)
  );

  // RAM64 stand-in and increment source.
  logic [DW-1:0] mem     [NV];
  logic [DW-1:0] inc_tab [NV];
  logic [DW-1:0] ref_mem [NV];

  always_ff @(posedge clk) if (ram_load) mem[ram_sel] <= ram_in;
  assign ram_out  = mem[ram_sel];
  assign inc_data = inc_tab[inc_addr];

  int tests = 0;
  int fails = 0;

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output int lat);
    @(posedge clk); #1;
    hif.host_req = 1'b1; hif.host_we = we; hif.host_addr = a; hif.host_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!hif.host_ack && lat < 400);
    hif.host_req = 1'b0;
    rd = hif.host_rdata;
  endtask

  task automatic write_chk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] rd; int lat;
    host_op(1'b1, a, d, rd, lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL host_write_latency addr=%0d got=%0d want=2", a, lat); end
    ref_mem[a] = d;
  endtask

  task automatic read_chk(input logic [AW-1:0] a);
    logic [DW-1:0] rd; int lat;
    host_op(1'b0, a, '0, rd, lat);
    tests++;
    if (lat !== 2 || rd !== ref_mem[a]) begin
      fails++; $display("FAIL host_read addr=%0d got=%h lat=%0d want=%h lat=2", a, rd, lat, ref_mem[a]);
    end
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  // Waits (bounded) for the first phase, then checks NV consecutive pre-update phases.
  task automatic collect_sweep(input int max_wait, output int w);
    w = 0;
    do begin
      @(posedge clk); #1; w++;
    end while (!phase_valid && w < max_wait);
    tests++;
    if (!phase_valid) begin fails++; $display("FAIL sweep_start_timeout waited=%0d", w); return; end
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      tests++;
      if (phase_valid !== 1'b1 || phase_voice !== AW'(i) || phase_out !== ref_mem[i] ||
          sweep_done !== (i == NV - 1) || hif.host_ack !== 1'b0) begin
        fails++;
        $display("FAIL sweep_voice i=%0d got v=%b voice=%0d out=%h done=%b ack=%b want voice=%0d out=%h done=%b",
                 i, phase_valid, phase_voice, phase_out, sweep_done, hif.host_ack, i, ref_mem[i], i == NV - 1);
      end
      ref_mem[i] = ref_mem[i] + inc_tab[i];
    end
    @(posedge clk); #1;
    tests++;
    if (phase_valid !== 1'b0 || sweep_done !== 1'b0) begin
      fails++; $display("FAIL sweep_end got valid=%b done=%b want 0 0", phase_valid, sweep_done);
    end
  endtask

  task automatic readback_all();
    for (int a = 0; a < NV; a++) read_chk(AW'(a));
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (phase_valid !== 1'b0 || phase_voice !== '0 || phase_out !== '0 || sweep_done !== 1'b0 ||
        overrun !== 1'b0 || hif.host_ack !== 1'b0 || hif.host_rdata !== '0 || ram_load !== 1'b0) begin
      fails++;
      $display("FAIL %s got valid=%b voice=%0d out=%h done=%b ovr=%b ack=%b rdata=%h load=%b want all 0",
               tag, phase_valid, phase_voice, phase_out, sweep_done, overrun, hif.host_ack, hif.host_rdata, ram_load);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    for (int i = 0; i < NV; i++) begin mem[i] = '0; ref_mem[i] = '0; inc_tab[i] = '0; end
    #23;
    check_reset_outputs("reset_state");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_host_write();
    write_chk(AW'(5), DW'(20'h12345));
    read_chk(AW'(5));
  endtask

  task automatic test_host_random();
    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, NV - 1));
      write_chk(a, DW'($urandom));
      read_chk(AW'($urandom_range(0, NV - 1)));
      read_chk(a);
    end
  endtask

  task automatic test_sweep();
    int w;
    for (int i = 0; i < NV; i++) begin write_chk(AW'(i), DW'(i)); inc_tab[i] = DW'(20'h00010); end
    pulse_tick();
    collect_sweep(4, w);
    tests++;
    if (w !== 1) begin fails++; $display("FAIL sweep_latency got=%0d want=1", w); end
    readback_all();
  endtask

  task automatic test_wrap();
    int w;
    write_chk(AW'(0), DW'(20'hFFFF8));
    pulse_tick();
    collect_sweep(4, w);
    tests++;
    if (ref_mem[0] !== DW'(20'h00008)) begin fails++; $display("FAIL wrap_model got=%h want=00008", ref_mem[0]); end
    read_chk(AW'(0));
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL wrap_no_flag got=%b want=0", overrun); end
  endtask

  task automatic test_random_sweep();
    int w;
    for (int i = 0; i < NV; i++) inc_tab[i] = DW'($urandom);
    for (int k = 0; k < 8; k++) write_chk(AW'($urandom_range(0, NV - 1)), DW'($urandom));
    repeat (2) begin pulse_tick(); collect_sweep(4, w); end
    readback_all();
  endtask

  task automatic test_collision();
    int w;
    logic [DW-1:0] d;
    // Tick and host request together: sweep first, then the host read.
    @(posedge clk); #1;
    sample_tick = 1'b1; hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = AW'(7);
    @(posedge clk); #1 sample_tick = 1'b0;
    collect_sweep(4, w);
    tests++;
    if (w !== 1 || hif.host_ack !== 1'b0) begin
      fails++; $display("FAIL collide_sweep_first got lat=%0d ack=%b want 1 0", w, hif.host_ack);
    end
    @(posedge clk); #1;
    tests++;
    if (hif.host_ack !== 1'b1 || hif.host_rdata !== ref_mem[7]) begin
      fails++; $display("FAIL collide_host_ack got ack=%b rdata=%h want 1 %h", hif.host_ack, hif.host_rdata, ref_mem[7]);
    end
    hif.host_req = 1'b0;
    // Tick while a host write is in HOST: deferred sweep.
    d = DW'($urandom);
    @(posedge clk); #1;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = AW'(9); hif.host_wdata = d;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    tests++;
    if (hif.host_ack !== 1'b1) begin fails++; $display("FAIL defer_ack got=%b want=1", hif.host_ack); end
    hif.host_req = 1'b0;
    ref_mem[9] = d;
    collect_sweep(8, w);
    tests++;
    if (w !== 3 || overrun !== 1'b0) begin
      fails++; $display("FAIL defer_sweep got lat=%0d ovr=%b want 3 0", w, overrun);
    end
    // Ticks in both HOST and ACK: one deferred sweep plus overrun.
    @(posedge clk); #1;
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = AW'(9);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1;
    hif.host_req = 1'b0;
    @(posedge clk); #1 sample_tick = 1'b0;
    collect_sweep(8, w);
    tests++;
    if (w !== 2 || overrun !== 1'b1) begin
      fails++; $display("FAIL double_pending got lat=%0d ovr=%b want 2 1", w, overrun);
    end
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic test_overrun();
    int w;
    int extra;
    pulse_tick();
    fork
      collect_sweep(4, w);
      begin
        repeat (30) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
      end
    join
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got=%b want=1", overrun); end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (phase_valid) extra++; end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL overrun_no_second_sweep got=%0d valid cycles want=0", extra); end
    overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr got=%b want=0", overrun); end
    // Set and clear in the same cycle: set wins.
    pulse_tick();
    fork
      collect_sweep(4, w);
      begin
        repeat (10) @(posedge clk);
        #1 begin sample_tick = 1'b1; overrun_clr = 1'b1; end
        @(posedge clk); #1 begin sample_tick = 1'b0; overrun_clr = 1'b0; end
      end
    join
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set_wins got=%b want=1", overrun); end
    overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int w;
    pulse_tick();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests++;
      if (phase_valid !== 1'b1 || phase_voice !== AW'(i) || phase_out !== ref_mem[i]) begin
        fails++; $display("FAIL partial_voice i=%0d got voice=%0d out=%h want %0d %h", i, phase_voice, phase_out, i, ref_mem[i]);
      end
      ref_mem[i] = ref_mem[i] + inc_tab[i];
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_mid_sweep");
    @(negedge clk) rst_n = 1'b1;
    readback_all();
    pulse_tick();
    collect_sweep(4, w);
    tests++;
    if (w !== 1) begin fails++; $display("FAIL restart_latency got=%0d want=1", w); end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_random();
    test_sweep();
    test_wrap();
    test_random_sweep();
    test_collision();
    test_overrun();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
